// File: rtl/data_c_rr_arbiter_if.sv
// data_inf_c: valid/ready/data stream interface shared by the arbiter's sources and its output.
interface data_inf_c #(
  parameter int DSIZE = 8
) (
  input logic clock
);
  logic             valid;
  logic             ready;
  logic [DSIZE-1:0] data;

  modport master (input clock, output valid, output data, input ready);
  modport slaver (input clock, input valid, input data, output ready);
endinterface

// File: rtl/data_c_rr_arbiter.sv
// data_c_rr_arbiter: NUM-to-1 round-robin stream arbiter with a registered output stage.
// Define DATA_C_ARB_LOCK_EN to hold a grant for up to BURST consecutive transfers.
module data_c_rr_arbiter #(
  parameter int NUM   = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic                   clock,
  input  logic                   rst,
  data_inf_c.slaver              slaver [0:NUM-1],
  data_inf_c.master              master,
  output logic [$clog2(NUM)-1:0] grant_id
);
  localparam int unsigned IW = $clog2(NUM);

  logic [NUM-1:0]   req;
  logic [DSIZE-1:0] din [NUM];
  logic [NUM-1:0]   ready_c;
  logic [IW-1:0]    sel_c;
  logic [IW-1:0]    idx_c;
  logic             sel_ok_c;
  logic             load_ok_c;
  logic             hs_c;
  logic             locked;
  logic [IW-1:0]    last;
  logic             out_valid;
  logic [DSIZE-1:0] out_data;

  if (NUM < 2 || NUM > 16) begin : g_num_chk
    $error("data_c_rr_arbiter: NUM must be in 2..16");
  end
  if (BURST < 1 || BURST > 256) begin : g_burst_chk
    $error("data_c_rr_arbiter: BURST must be in 1..256");
  end

  for (genvar i = 0; i < NUM; i++) begin : g_port
    assign req[i]          = slaver[i].valid;
    assign din[i]          = slaver[i].data;
    assign slaver[i].ready = ready_c[i];
    if ($bits(slaver[i].data) != $bits(master.data)) begin : g_dsize_chk
      $error("data_c_rr_arbiter: slaver DSIZE differs from master DSIZE");
    end
  end

  assign load_ok_c    = !out_valid || master.ready;
  assign hs_c         = |ready_c;
  assign master.valid = out_valid;
  assign master.data  = out_data;

`ifdef DATA_C_ARB_LOCK_EN
  localparam int unsigned CW = $clog2(BURST) + 1;

  typedef enum logic {ARB, LOCK} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= ARB;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt counts transfers taken while in LOCK; the ARB acceptance is the first of the burst.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ARB: begin
        cnt_nxt = '0;
        if (hs_c && BURST > 1) state_nxt = LOCK;
      end
      LOCK: begin
        if (hs_c) begin
          if (cnt == CW'(BURST - 2)) begin
            state_nxt = ARB;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else if (!req[last] && load_ok_c) begin
          state_nxt = ARB;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ARB;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign locked = (state == LOCK);
`else
  assign locked = 1'b0;
`endif

  // Selection: locked source, else first requester after last; smallest offset written last wins.
  always_comb begin
    sel_c    = last;
    idx_c    = last;
    sel_ok_c = 1'b0;
    ready_c  = '0;
    if (locked) begin
      sel_ok_c = req[last];
    end else begin
      for (int k = NUM; k >= 1; k--) begin
        idx_c = IW'((int'(last) + k) % NUM);
        if (req[idx_c]) begin
          sel_c    = idx_c;
          sel_ok_c = 1'b1;
        end
      end
    end
    if (!rst && sel_ok_c && load_ok_c) ready_c[sel_c] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_id  <= '0;
      last      <= IW'(NUM - 1);
    end else if (load_ok_c) begin
      out_valid <= hs_c;
      if (hs_c) begin
        out_data <= din[sel_c];
        grant_id <= sel_c;
        last     <= sel_c;
      end
    end
  end
endmodule

// File: tb/tb_data_c_rr_arbiter.sv
// Bench for data_c_rr_arbiter: directed vector table, burst/grant sequences and a randomized
// run against a behavioural model (lock behaviour follows DATA_C_ARB_LOCK_EN).
module tb_data_c_rr_arbiter;
  localparam int NUM   = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;
`ifdef DATA_C_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [NUM-1:0] v;
  logic [DW-1:0]  d [NUM];
  logic           mrdy;
  logic [NUM-1:0] rdy;
  logic [1:0]     gid;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model state
  int m_mv, m_md, m_gid, m_last, m_owner, m_taken;

  data_inf_c #(.DSIZE(DW)) s_if [0:NUM-1] (.clock(clk));
  data_inf_c #(.DSIZE(DW)) m_if (.clock(clk));

  for (genvar g = 0; g < NUM; g++) begin : g_src
    assign s_if[g].valid = v[g];
    assign s_if[g].data  = d[g];
    assign rdy[g]        = s_if[g].ready;
  end
  assign m_if.ready = mrdy;

  data_c_rr_arbiter #(.NUM(NUM), .DSIZE(DW), .BURST(BURST)) dut (
    .clock    (clk),
    .rst      (rst),
    .slaver   (s_if),
    .master   (m_if),
    .grant_id (gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        rst;
    bit [3:0]  v;
    bit [31:0] d;
    bit        mrdy;
    bit [3:0]  e_rdy;
    bit        e_mv;
    bit [1:0]  e_gid;
    bit [7:0]  e_dat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mv = 0; m_md = 0; m_gid = 0; m_last = NUM - 1; m_owner = -1; m_taken = 0;
  endtask

  // Compare current DUT outputs against the model, then advance the model by one clock edge.
  task automatic model_cycle();
    int  cand;
    bit  can;
    int  er;
    cand = -1;
    can  = (m_mv == 0) || mrdy;
    if (!rst) begin
      if (m_owner >= 0) begin
        if (v[m_owner]) cand = m_owner;
      end else begin
        for (int k = 1; k <= NUM && cand < 0; k++)
          if (v[(m_last + k) % NUM]) cand = (m_last + k) % NUM;
      end
    end
    er = (can && cand >= 0) ? (1 << cand) : 0;
    chk("model_ready", int'(rdy), er);
    chk("model_valid", int'(m_if.valid), m_mv);
    chk("model_grant", int'(gid), m_gid);
    chk("model_data", int'(m_if.data), m_md);
    if (rst) begin
      model_reset();
    end else if (can) begin
      if (cand >= 0) begin
        m_mv = 1; m_md = int'(d[cand]); m_gid = cand; m_last = cand;
        if (LOCK) begin
          if (m_owner < 0) begin
            m_taken = 1;
            if (BURST > 1) m_owner = cand;
          end else begin
            m_taken++;
          end
          if (m_taken >= BURST) begin
            m_owner = -1;
            m_taken = 0;
          end
        end
      end else begin
        m_mv = 0;
        m_owner = -1;
        m_taken = 0;
      end
    end
  endtask

  task automatic cycle_end();
    model_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_data(input bit [31:0] w);
    for (int i = 0; i < NUM; i++) d[i] = w[8*i +: 8];
  endtask

  initial begin
    vec_t      tab [20];
    bit [31:0] d1, d2;
    d1 = 32'h33A5_2211;
    d2 = 32'h335A_2211;
    tab[0]  = '{0, 4'b0000, d1, 1, 4'b0000, 0, 2'd0, 8'h00};
    tab[1]  = '{0, 4'b0100, d1, 0, 4'b0100, 0, 2'd0, 8'h00};
    tab[2]  = '{0, 4'b0100, d2, 0, 4'b0000, 1, 2'd2, 8'hA5};
    tab[3]  = '{0, 4'b0100, d2, 0, 4'b0000, 1, 2'd2, 8'hA5};
    tab[4]  = '{0, 4'b0100, d2, 0, 4'b0000, 1, 2'd2, 8'hA5};
    tab[5]  = '{0, 4'b0100, d2, 0, 4'b0000, 1, 2'd2, 8'hA5};
    tab[6]  = '{0, 4'b0100, d2, 0, 4'b0000, 1, 2'd2, 8'hA5};
    tab[7]  = '{0, 4'b0100, d2, 1, 4'b0100, 1, 2'd2, 8'hA5};
    tab[8]  = '{0, 4'b0000, d2, 1, 4'b0000, 1, 2'd2, 8'h5A};
    tab[9]  = '{0, 4'b0000, d2, 1, 4'b0000, 0, 2'd2, 8'h5A};
    tab[10] = '{0, 4'b1001, d2, 1, 4'b1000, 0, 2'd2, 8'h5A};
    tab[11] = '{0, 4'b0000, d2, 1, 4'b0000, 1, 2'd3, 8'h33};
    tab[12] = '{0, 4'b0000, d2, 1, 4'b0000, 0, 2'd3, 8'h33};
    tab[13] = '{0, 4'b0011, d2, 1, 4'b0001, 0, 2'd3, 8'h33};
    tab[14] = '{0, 4'b0011, d2, 0, 4'b0000, 1, 2'd0, 8'h11};
    tab[15] = '{1, 4'b0011, d2, 0, 4'b0000, 1, 2'd0, 8'h11};
    tab[16] = '{0, 4'b0110, d2, 0, 4'b0010, 0, 2'd0, 8'h00};
    tab[17] = '{0, 4'b0000, d2, 0, 4'b0000, 1, 2'd1, 8'h22};
    tab[18] = '{0, 4'b0000, d2, 1, 4'b0000, 1, 2'd1, 8'h22};
    tab[19] = '{0, 4'b0000, d2, 1, 4'b0000, 0, 2'd1, 8'h22};

    model_reset();
    rst = 1'b1; v = '0; mrdy = 1'b0; set_data(32'h0);
    @(negedge clk);
    #1;
    cycle_end();

    // Directed vector table
    for (int r = 0; r < 20; r++) begin
      rst = tab[r].rst; v = tab[r].v; mrdy = tab[r].mrdy; set_data(tab[r].d);
      #1;
      chk("tab_ready", int'(rdy), int'(tab[r].e_rdy));
      chk("tab_valid", int'(m_if.valid), int'(tab[r].e_mv));
      chk("tab_grant", int'(gid), int'(tab[r].e_gid));
      chk("tab_data", int'(m_if.data), int'(tab[r].e_dat));
      cycle_end();
    end

    // Continuous requests with the output always draining: grant order check
    rst = 1'b1; v = '0; mrdy = 1'b1;
    #1; cycle_end();
    rst = 1'b0;
    v = LOCK ? 4'b0011 : 4'b1111;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < NUM; i++) d[i] = DW'($urandom);
      #1;
      if (k == 0) begin
        chk("seq_first_valid", int'(m_if.valid), 0);
      end else begin
        chk("seq_valid", int'(m_if.valid), 1);
        chk("seq_grant", int'(gid), LOCK ? ((k - 1) / BURST) % 2 : (k - 1) % NUM);
      end
      cycle_end();
    end

`ifdef DATA_C_ARB_LOCK_EN
    // Locked source drops valid mid-burst: abandon after one idle cycle, then grant source 3
    rst = 1'b1; v = '0; mrdy = 1'b1;
    #1; cycle_end();
    rst = 1'b0; v = 4'b1001;
    #1; chk("abandon_rdy0", int'(rdy), 4'b0001); cycle_end();
    #1; chk("abandon_rdy1", int'(rdy), 4'b0001); cycle_end();
    v = 4'b1000;
    #1; chk("abandon_idle", int'(rdy), 4'b0000); cycle_end();
    #1; chk("abandon_next", int'(rdy), 4'b1000); cycle_end();
    v = 4'b0000;
    #1; chk("abandon_grant", int'(gid), 3); cycle_end();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 63) == 0);
      v    = NUM'($urandom);
      mrdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM; i++) d[i] = DW'($urandom);
      #1;
      cycle_end();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
